// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if: control, instruction-memory and IF/ID signals between the fetch stage and its neighbours.
interface if_id_fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_imm_ext;
    logic        jump;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [15:0] imm16;
    logic [31:0] pc;

    modport master (
        input  stall, branch_taken, branch_imm_ext, jump, imem_data,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, imm16, pc
    );

    modport slave (
        output stall, branch_taken, branch_imm_ext, jump, imem_data,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, imm16, pc
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC register, instruction fetch and IF/ID pipeline register with branch/jump redirect.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    if_id_fetch_stage_if.master    bus
);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4, branch_target, jump_target, target;
    logic        redirect, squash;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc4_q + (bus.branch_imm_ext << 2);
        jump_target   = {pc4_q[31:28], instr_q[25:0], 2'b00};
        target        = bus.branch_taken ? branch_target : jump_target;
        redirect      = (bus.branch_taken | bus.jump) & valid_q;
        // Without a delay slot, the word fetched alongside a redirect is turned into a bubble.
        squash        = redirect & ~DELAY_SLOT;
        pc_d          = bus.stall ? pc_q    : (redirect ? {target[31:2], 2'b00} : pc_plus4);
        instr_d       = bus.stall ? instr_q : (squash ? 32'h0 : bus.imem_data);
        pc4_d         = bus.stall ? pc4_q   : pc_plus4;
        valid_d       = bus.stall ? valid_q : ~squash;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.imm16       = instr_q[15:0];
endmodule
